// File: rtl/hack_pkg.sv
// Shared definitions for the multi-cycle Hack CPU.
//   state_e     : control FSM states
//   Ir*         : bit positions of the C-instruction fields
//   jump_taken  : decodes the j1..j3 jump condition against the ALU flags
package hack_pkg;

   typedef enum logic [2:0] {
      StBoot,
      StFetch,
      StDecode,
      StMemRd,
      StExec,
      StMemWr
   } state_e;

   // C-instruction layout: 1 x x a c1..c6 d1 d2 d3 j1 j2 j3
   localparam int unsigned IrABit    = 12;
   localparam int unsigned IrCompLsb = 6;
   localparam int unsigned IrDestA   = 5;
   localparam int unsigned IrDestD   = 4;
   localparam int unsigned IrDestM   = 3;

   // j[2]=j1 (out<0), j[1]=j2 (out==0), j[0]=j3 (out>0)
   function automatic logic jump_taken(input logic [2:0] j, input logic ng, input logic zr);
      return (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
   endfunction

endpackage

// File: rtl/hack_alu_w.sv
// Width-parametrised combinational Hack ALU.
//   x, y            : operands (x = D, y = A or M)
//   zx,nx,zy,ny,f,no: control bits c1..c6
//   out             : result, wraps modulo 2**WIDTH
//   zr, ng          : out == 0, out < 0 (msb)
module hack_alu_w #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             zx,
   input  logic             nx,
   input  logic             zy,
   input  logic             ny,
   input  logic             f,
   input  logic             no,
   output logic [WIDTH-1:0] out,
   output logic             zr,
   output logic             ng
);

   logic [WIDTH-1:0] xa, xb, ya, yb, fo;

   always_comb begin
      xa  = zx ? '0 : x;
      xb  = nx ? ~xa : xa;
      ya  = zy ? '0 : y;
      yb  = ny ? ~ya : ya;
      fo  = f ? (xb + yb) : (xb & yb);
      out = no ? ~fo : fo;
      ng  = out[WIDTH-1];
      zr  = (out == '0);
   end

endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU with req/ack handshakes to instruction and data memories.
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   imem_req/addr/ack/rdata : instruction fetch port (addr = pc)
//   dmem_req/we/addr/wdata/ack/rdata : data port (M reads and writes)
//   pc                    : current program counter
//   instret               : retired-instruction counter, present only when
//                           HACK_CPU_INSTRET_EN is defined
module hack_cpu_mc
   import hack_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AW    = 15,
   parameter int unsigned PCW   = 15
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   output logic [PCW-1:0]   imem_addr,
   input  logic             imem_ack,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [AW-1:0]    dmem_addr,
   output logic [WIDTH-1:0] dmem_wdata,
   input  logic             dmem_ack,
   input  logic [WIDTH-1:0] dmem_rdata,
   output logic [PCW-1:0]   pc
`ifdef HACK_CPU_INSTRET_EN
   ,
   output logic [31:0]      instret
`endif
);

   state_e           state_q, state_d;
   logic [PCW-1:0]   pc_q, pc_d;
   logic [PCW-1:0]   pc_pend_q, pc_pend_d;  // PC to commit once a pending M write completes
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] ir_q, ir_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic             pc_upd;

   logic [WIDTH-1:0] alu_out;
   logic             alu_zr, alu_ng;
   logic [PCW-1:0]   pc_inc;
   logic [PCW-1:0]   pc_target;
   logic [5:0]       comp;

   assign comp   = ir_q[IrCompLsb+5:IrCompLsb];
   assign pc_inc = pc_q + PCW'(1);

   hack_alu_w #(
      .WIDTH (WIDTH)
   ) u_alu (
      .x   (d_q),
      .y   (ir_q[IrABit] ? m_q : a_q),
      .zx  (comp[5]),
      .nx  (comp[4]),
      .zy  (comp[3]),
      .ny  (comp[2]),
      .f   (comp[1]),
      .no  (comp[0]),
      .out (alu_out),
      .zr  (alu_zr),
      .ng  (alu_ng)
   );

   // Target uses A before this instruction's own A update (a_q is still old in EXEC).
   assign pc_target = jump_taken(ir_q[2:0], alu_ng, alu_zr) ? a_q[PCW-1:0] : pc_inc;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pc_pend_d = pc_pend_q;
      a_d       = a_q;
      d_d       = d_q;
      ir_d      = ir_q;
      m_d       = m_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      pc_upd    = 1'b0;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;

      unique case (state_q)
         StBoot: state_d = StFetch;
         StFetch: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_d    = imem_rdata;
               state_d = StDecode;
            end
         end
         StDecode: begin
            if (!ir_q[WIDTH-1]) begin
               a_d     = {1'b0, ir_q[WIDTH-2:0]};
               pc_d    = pc_inc;
               pc_upd  = 1'b1;
               state_d = StFetch;
            end else if (ir_q[IrABit]) begin
               addr_d  = a_q[AW-1:0];
               state_d = StMemRd;
            end else begin
               state_d = StExec;
            end
         end
         StMemRd: begin
            dmem_req = 1'b1;
            if (dmem_ack) begin
               m_d     = dmem_rdata;
               state_d = StExec;
            end
         end
         StExec: begin
            if (ir_q[IrDestD]) d_d = alu_out;
            if (ir_q[IrDestA]) a_d = alu_out;
            if (ir_q[IrDestM]) begin
               addr_d    = a_q[AW-1:0];
               wdata_d   = alu_out;
               pc_pend_d = pc_target;
               state_d   = StMemWr;
            end else begin
               pc_d    = pc_target;
               pc_upd  = 1'b1;
               state_d = StFetch;
            end
         end
         StMemWr: begin
            dmem_req = 1'b1;
            dmem_we  = 1'b1;
            if (dmem_ack) begin
               pc_d    = pc_pend_q;
               pc_upd  = 1'b1;
               state_d = StFetch;
            end
         end
         default: state_d = StBoot;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StBoot;
         pc_q      <= '0;
         pc_pend_q <= '0;
         a_q       <= '0;
         d_q       <= '0;
         ir_q      <= '0;
         m_q       <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pc_pend_q <= pc_pend_d;
         a_q       <= a_d;
         d_q       <= d_d;
         ir_q      <= ir_d;
         m_q       <= m_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
      end
   end

   assign imem_addr  = pc_q;
   assign pc         = pc_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;

`ifdef HACK_CPU_INSTRET_EN
   logic [31:0] instret_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instret_q <= '0;
      end else if (pc_upd) begin
         instret_q <= instret_q + 32'd1;
      end
   end

   assign instret = instret_q;
`else
   logic unused_pc_upd;
   assign unused_pc_upd = pc_upd;
`endif

   // Bits between the dest/comp fields and the C-instruction marker carry no meaning.
   logic unused_ir;
   assign unused_ir = ^ir_q[WIDTH-2:IrABit+1];

endmodule
